// File: rtl/dual_grant_arbiter_12b_pkg.sv
// Shared types and constants for the 12-requester dual-slot arbiter.
// Round-robin priority is enabled by defining DUAL_ARB_ROUND_ROBIN_EN.
package dual_grant_arbiter_12b_pkg;

    localparam int N_REQ    = 12;
    localparam int IDX_W    = 4;
    localparam int TENURE_W = 8;

    localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;
    localparam logic [IDX_W-1:0] PTR_TOP  = 4'd11;

    typedef enum logic {
        SLOT_IDLE,
        SLOT_OWNED
    } slot_state_e;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic valid, input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        if (valid) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dual_grant_arbiter_12b_pick.sv
// Combinational dual-priority picker: first and second highest-priority set bits.
// With DUAL_ARB_ROUND_ROBIN_EN the order starts at ptr_i and wraps downward.
module dual_pick_12b
    import dual_grant_arbiter_12b_pkg::*;
(
    input  logic [N_REQ-1:0] elig_i,
`ifdef DUAL_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [IDX_W-1:0] first_idx_o,
    output logic             first_valid_o,
    output logic [IDX_W-1:0] second_idx_o,
    output logic             second_valid_o
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   first_pick;
    logic [IDX_W:0]   second_pick;

    // Scans from lowest to highest priority so the last hit is the winner.
    function automatic logic [IDX_W:0] pick_top(input logic [N_REQ-1:0] vec, input logic [IDX_W-1:0] top);
        logic [IDX_W:0] r;
        int             j;
        r = {1'b0, IDX_NONE};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(top) - k;
            if (j < 0) begin
                j = j + N_REQ;
            end
            if (vec[j[IDX_W-1:0]]) begin
                r = {1'b1, j[IDX_W-1:0]};
            end
        end
        return r;
    endfunction

`ifdef DUAL_ARB_ROUND_ROBIN_EN
    assign ptr = ptr_i;
`else
    assign ptr = PTR_TOP;
`endif

    always_comb begin
        first_pick  = pick_top(elig_i, ptr);
        second_pick = pick_top(elig_i & ~idx_onehot(first_pick[IDX_W], first_pick[IDX_W-1:0]), ptr);
    end

    assign first_valid_o  = first_pick[IDX_W];
    assign first_idx_o    = first_pick[IDX_W-1:0];
    assign second_valid_o = second_pick[IDX_W];
    assign second_idx_o   = second_pick[IDX_W-1:0];

endmodule

// File: rtl/dual_grant_arbiter_12b.sv
// Two-slot arbiter for 12 requesters with tenure timeout and same-edge refill.
// Define DUAL_ARB_ROUND_ROBIN_EN to replace fixed priority with a rotating pointer.
module dual_grant_arbiter_12b
    import dual_grant_arbiter_12b_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_a_valid,
    output logic [IDX_W-1:0] gnt_a_idx,
    output logic             gnt_b_valid,
    output logic [IDX_W-1:0] gnt_b_idx,
    output logic [N_REQ-1:0] revoked,
    output logic             busy
);

    localparam logic [TENURE_W-1:0] HOLD_LAST = TENURE_W'(HOLD_MAX - 1);

    slot_state_e         st_q  [2];
    slot_state_e         st_d  [2];
    logic [IDX_W-1:0]    own_q [2];
    logic [IDX_W-1:0]    own_d [2];
    logic [TENURE_W-1:0] cnt_q [2];
    logic [TENURE_W-1:0] cnt_d [2];
    logic [N_REQ-1:0]    revoked_q;
    logic [N_REQ-1:0]    revoked_d;
    logic [N_REQ-1:0]    own_mask;
    logic [N_REQ-1:0]    elig;
    logic [IDX_W-1:0]    first_idx;
    logic [IDX_W-1:0]    second_idx;
    logic                first_valid;
    logic                second_valid;
`ifdef DUAL_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    ptr_d;
    logic                grant_made;
    logic [IDX_W-1:0]    last_idx;
`endif

    dual_pick_12b u_pick (
        .elig_i         (elig),
`ifdef DUAL_ARB_ROUND_ROBIN_EN
        .ptr_i          (ptr_q),
`endif
        .first_idx_o    (first_idx),
        .first_valid_o  (first_valid),
        .second_idx_o   (second_idx),
        .second_valid_o (second_valid)
    );

    // Every current owner is masked from eligibility, so a slot freed this edge
    // can never go straight back to the requester that just lost it.
    always_comb begin
        revoked_d = revoked_q & req;
        own_mask  = '0;
        for (int s = 0; s < 2; s++) begin
            st_d[s]  = st_q[s];
            own_d[s] = own_q[s];
            cnt_d[s] = cnt_q[s];
            if (st_q[s] == SLOT_OWNED) begin
                own_mask = own_mask | idx_onehot(1'b1, own_q[s]);
                if (!req[own_q[s]]) begin
                    st_d[s] = SLOT_IDLE;
                end else if (HOLD_MAX != 0 && cnt_q[s] == HOLD_LAST) begin
                    st_d[s]              = SLOT_IDLE;
                    revoked_d[own_q[s]]  = 1'b1;
                end else if (cnt_q[s] != '1) begin
                    cnt_d[s] = cnt_q[s] + 1'b1;
                end
                if (st_d[s] == SLOT_IDLE) begin
                    own_d[s] = IDX_NONE;
                    cnt_d[s] = '0;
                end
            end
        end

        elig = req & ~revoked_q & ~own_mask;

`ifdef DUAL_ARB_ROUND_ROBIN_EN
        grant_made = 1'b0;
        last_idx   = first_idx;
`endif
        if (first_valid) begin
            if (st_d[0] == SLOT_IDLE) begin
                st_d[0]  = SLOT_OWNED;
                own_d[0] = first_idx;
                cnt_d[0] = '0;
`ifdef DUAL_ARB_ROUND_ROBIN_EN
                grant_made = 1'b1;
`endif
                if (st_d[1] == SLOT_IDLE && second_valid) begin
                    st_d[1]  = SLOT_OWNED;
                    own_d[1] = second_idx;
                    cnt_d[1] = '0;
`ifdef DUAL_ARB_ROUND_ROBIN_EN
                    last_idx = second_idx;
`endif
                end
            end else if (st_d[1] == SLOT_IDLE) begin
                st_d[1]  = SLOT_OWNED;
                own_d[1] = first_idx;
                cnt_d[1] = '0;
`ifdef DUAL_ARB_ROUND_ROBIN_EN
                grant_made = 1'b1;
`endif
            end
        end
    end

`ifdef DUAL_ARB_ROUND_ROBIN_EN
    // The next search starts just below the most recent winner, wrapping 0 -> 11.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_made) begin
            ptr_d = (last_idx == '0) ? PTR_TOP : last_idx - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_TOP;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]  <= SLOT_IDLE;
                own_q[s] <= IDX_NONE;
                cnt_q[s] <= '0;
            end
            revoked_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]  <= st_d[s];
                own_q[s] <= own_d[s];
                cnt_q[s] <= cnt_d[s];
            end
            revoked_q <= revoked_d;
        end
    end

    assign gnt_a_valid = (st_q[0] == SLOT_OWNED);
    assign gnt_b_valid = (st_q[1] == SLOT_OWNED);
    assign gnt_a_idx   = own_q[0];
    assign gnt_b_idx   = own_q[1];
    assign gnt         = idx_onehot(gnt_a_valid, own_q[0]) | idx_onehot(gnt_b_valid, own_q[1]);
    assign revoked     = revoked_q;
    assign busy        = gnt_a_valid | gnt_b_valid;

endmodule

// File: tb/tb_dual_grant_arbiter_12b.sv
// Scoreboard bench for dual_grant_arbiter_12b using three HOLD_MAX variants (15, 4, 1).
// The rotation scenario runs only when DUAL_ARB_ROUND_ROBIN_EN is defined.
module tb_dual_grant_arbiter_12b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] req15 = '0, req4 = '0, req1 = '0;

    logic [11:0] gnt15, gnt4, gnt1, rev15, rev4, rev1;
    logic        av15, av4, av1, bv15, bv4, bv1, busy15, busy4, busy1;
    logic [3:0]  ai15, ai4, ai1, bi15, bi4, bi1;

    logic [34:0] obs15, obs4, obs1;
    logic [34:0] expQ [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dual_grant_arbiter_12b #(.HOLD_MAX(15)) u15 (
        .clk(clk), .rst_n(rst_n), .req(req15), .gnt(gnt15),
        .gnt_a_valid(av15), .gnt_a_idx(ai15), .gnt_b_valid(bv15), .gnt_b_idx(bi15),
        .revoked(rev15), .busy(busy15)
    );

    dual_grant_arbiter_12b #(.HOLD_MAX(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4),
        .gnt_a_valid(av4), .gnt_a_idx(ai4), .gnt_b_valid(bv4), .gnt_b_idx(bi4),
        .revoked(rev4), .busy(busy4)
    );

    dual_grant_arbiter_12b #(.HOLD_MAX(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1),
        .gnt_a_valid(av1), .gnt_a_idx(ai1), .gnt_b_valid(bv1), .gnt_b_idx(bi1),
        .revoked(rev1), .busy(busy1)
    );

    assign obs15 = {gnt15, av15, ai15, bv15, bi15, rev15, busy15};
    assign obs4  = {gnt4,  av4,  ai4,  bv4,  bi4,  rev4,  busy4};
    assign obs1  = {gnt1,  av1,  ai1,  bv1,  bi1,  rev1,  busy1};

    // Expected output vector; a negative slot index means the slot is idle.
    function automatic logic [34:0] expV(input int a, input int b, input logic [11:0] rev);
        logic [11:0] g;
        logic        av, bv;
        logic [3:0]  ai, bi;
        g  = '0;
        av = (a >= 0);
        bv = (b >= 0);
        ai = av ? a[3:0] : 4'hF;
        bi = bv ? b[3:0] : 4'hF;
        if (av) g[ai] = 1'b1;
        if (bv) g[bi] = 1'b1;
        return {g, av, ai, bv, bi, rev, av | bv};
    endfunction

    task automatic test_reset();
        logic [34:0] e;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        e = expV(-1, -1, 12'h000);
        vectors += 3;
        if (obs15 !== e) begin miscompares++; $display("[TB] FAIL reset_u15: got %h expected %h", obs15, e); end
        if (obs4  !== e) begin miscompares++; $display("[TB] FAIL reset_u4: got %h expected %h", obs4, e); end
        if (obs1  !== e) begin miscompares++; $display("[TB] FAIL reset_u1: got %h expected %h", obs1, e); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req15 = 12'h000;
            expQ.push_back(expV(-1, -1, 12'h000));
            @(posedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if (obs15 !== e) begin miscompares++; $display("[TB] FAIL idle[%0d]: got %h expected %h", i, obs15, e); end
        end
    endtask

    task automatic test_priority_refill();
        logic [34:0] e;
        logic [11:0] reqT [8] = '{12'h881, 12'h081, 12'h000, 12'h00F, 12'h00B, 12'h009, 12'h001, 12'h000};
        int          aT   [8] = '{11, 0, -1, 3, 3, 3, -1, -1};
        int          bT   [8] = '{7, 7, -1, 2, 1, 0, 0, -1};
        for (int i = 0; i < 8; i++) begin
            req15 = reqT[i];
            expQ.push_back(expV(aT[i], bT[i], 12'h000));
            @(posedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if (obs15 !== e) begin miscompares++; $display("[TB] FAIL prio[%0d]: got %h expected %h", i, obs15, e); end
        end
    endtask

    task automatic test_timeout();
        logic [34:0] e;
        logic [11:0] reqT [15] = '{12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h000, 12'h001,
                                   12'h000, 12'h003, 12'h003, 12'h003, 12'h003, 12'h001, 12'h000};
        int          aT   [15] = '{0, 0, 0, 0, -1, -1, -1, 0, -1, 1, 1, 1, 1, -1, -1};
        int          bT   [15] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0, -1, -1};
        logic [11:0] rT   [15] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h001, 12'h001, 12'h000, 12'h000,
                                   12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h001, 12'h000};
        for (int i = 0; i < 15; i++) begin
            req4 = reqT[i];
            expQ.push_back(expV(aT[i], bT[i], rT[i]));
            @(posedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if (obs4 !== e) begin miscompares++; $display("[TB] FAIL timeout[%0d]: got %h expected %h", i, obs4, e); end
        end
    endtask

    task automatic test_hold_one();
        logic [34:0] e;
        logic [11:0] reqT [3] = '{12'h003, 12'h003, 12'h000};
        int          aT   [3] = '{1, -1, -1};
        int          bT   [3] = '{0, -1, -1};
        logic [11:0] rT   [3] = '{12'h000, 12'h003, 12'h000};
        for (int i = 0; i < 3; i++) begin
            req1 = reqT[i];
            expQ.push_back(expV(aT[i], bT[i], rT[i]));
            @(posedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if (obs1 !== e) begin miscompares++; $display("[TB] FAIL hold1[%0d]: got %h expected %h", i, obs1, e); end
        end
    endtask

`ifdef DUAL_ARB_ROUND_ROBIN_EN
    // Revoked requesters drop req for one edge so their flag clears and they rejoin.
    task automatic test_round_robin();
        logic [34:0] e;
        logic [11:0] revExp;
        logic [11:0] newRev;
        int          grantCount [12];
        int          a, b, pa;
        for (int i = 0; i < 12; i++) grantCount[i] = 0;
        revExp = '0;
        for (int k = 0; k < 13; k++) begin
            a  = 11 - 2 * (k % 6);
            b  = a - 1;
            pa = 11 - 2 * ((k + 5) % 6);
            newRev = '0;
            if (k > 0) begin
                newRev[pa]     = 1'b1;
                newRev[pa - 1] = 1'b1;
            end
            req1 = 12'hFFF & ~revExp;
            expQ.push_back(expV(a, b, newRev));
            @(posedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if (obs1 !== e) begin miscompares++; $display("[TB] FAIL rr[%0d]: got %h expected %h", k, obs1, e); end
            if (k < 12) begin
                for (int i = 0; i < 12; i++) if (gnt1[i]) grantCount[i]++;
            end
            revExp = newRev;
        end
        req1 = 12'h000;
        expQ.push_back(expV(-1, -1, 12'h000));
        @(posedge clk); #1;
        e = expQ.pop_front();
        vectors++;
        if (obs1 !== e) begin miscompares++; $display("[TB] FAIL rr_drain: got %h expected %h", obs1, e); end
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (grantCount[i] !== 2) begin
                miscompares++;
                $display("[TB] FAIL rr_fair[%0d]: got %0d grants expected 2", i, grantCount[i]);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [34:0] e;
        req15 = 12'h0C0;
        expQ.push_back(expV(7, 6, 12'h000));
        @(posedge clk); #1;
        e = expQ.pop_front();
        vectors++;
        if (obs15 !== e) begin miscompares++; $display("[TB] FAIL pre_reset: got %h expected %h", obs15, e); end
        #2;
        rst_n = 1'b0;
        #1;
        e = expV(-1, -1, 12'h000);
        vectors++;
        if (obs15 !== e) begin miscompares++; $display("[TB] FAIL async_reset: got %h expected %h", obs15, e); end
        req15 = 12'h030;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(expV(5, 4, 12'h000));
        @(posedge clk); #1;
        e = expQ.pop_front();
        vectors++;
        if (obs15 !== e) begin miscompares++; $display("[TB] FAIL post_reset: got %h expected %h", obs15, e); end
        req15 = 12'h000;
        expQ.push_back(expV(-1, -1, 12'h000));
        @(posedge clk); #1;
        e = expQ.pop_front();
        vectors++;
        if (obs15 !== e) begin miscompares++; $display("[TB] FAIL post_idle: got %h expected %h", obs15, e); end
    endtask

    initial begin
        test_reset();
        test_priority_refill();
        test_timeout();
        test_hold_one();
`ifdef DUAL_ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
